// File: rtl/trig_capture_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trig_capture_tx_pkg
//  Description : Shared definitions for the trigger-capture UART block.
//                Holds the sequencer state enumeration, the frame header
//                byte, the ADC sample width and a helper that splits a
//                sample into its high/low transmit bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package trig_capture_tx_pkg;

    localparam int         ADC_W  = 14;
    localparam logic [7:0] HEADER = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    // High byte carries the top six sample bits zero-padded; low byte the
    // bottom eight.
    function automatic logic [7:0] sample_byte(input logic [ADC_W-1:0] s,
                                               input logic             hi);
        return hi ? {2'b00, s[ADC_W-1:8]} : s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/trig_capture_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : trig_capture_tx_if
//  Description : Bundle of the capture block's data-path signals.
//                  ADC_IN  : 14-bit unsigned sample, valid every clock
//                  trigger : level from the threshold trigger block
//                  tx      : UART serial out, 8N1, idle high
//                  busy    : high while capturing or sending
//                master modport = sample source / UART sink
//                slave  modport = trig_capture_tx
//  Revision    : 1.0 - initial release
// ============================================================================
interface trig_capture_tx_if;
    import trig_capture_tx_pkg::*;

    logic [ADC_W-1:0] ADC_IN;
    logic             trigger;
    logic             tx;
    logic             busy;

    modport master (output ADC_IN, output trigger, input tx, input busy);
    modport slave  (input ADC_IN, input trigger, output tx, output busy);

endinterface
`default_nettype wire

// File: rtl/trig_capture_tx_uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serialiser. A start pulse while idle, or during
//                the final clock of a stop bit, loads a new byte so frames
//                run back to back with no idle gap. o_done is high for the
//                last clock of the stop bit.
//                  clk     : system clock
//                  rst_n   : asynchronous active-low reset (tx forced high)
//                  i_data  : byte to send, sampled when accepted
//                  i_start : request to send i_data
//                  o_tx    : serial output
//                  o_done  : last clock of the current frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLK_DIV = 434
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire  [7:0] i_data,
    input  wire        i_start,
    output logic       o_tx,
    output logic       o_done
);

    localparam int CW = $clog2(CLK_DIV);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;      // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]    r_frame;    // remaining data bits followed by the stop bit
    logic          r_tx;

    logic w_bit_end;
    logic w_last;

    assign w_bit_end = r_active && (r_cnt == CW'(CLK_DIV - 1));
    assign w_last    = w_bit_end && (r_bit == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_frame  <= '1;
            r_tx     <= 1'b1;
        end else if (i_start && (!r_active || w_last)) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_frame  <= {1'b1, i_data};
            r_tx     <= 1'b0;
        end else if (w_last) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
        end else if (w_bit_end) begin
            r_cnt    <= '0;
            r_bit    <= r_bit + 4'd1;
            r_tx     <= r_frame[0];
            r_frame  <= {1'b1, r_frame[8:1]};
        end else if (r_active) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_tx   = r_tx;
    assign o_done = w_last;

endmodule
`default_nettype wire

// File: rtl/trig_capture_tx.sv
`default_nettype none
// ============================================================================
//  Module      : trig_capture_tx
//  Description : On a rising trigger edge, captures DEPTH consecutive ADC
//                samples, then streams them over UART as a header byte 0xA5
//                followed by {hi, lo} byte pairs per sample.
//                  CLOCK_50 : system clock (rising edge)
//                  RESET_N  : asynchronous active-low reset
//                  bus      : ADC_IN / trigger in, tx / busy out
//                Parameters: CLK_DIV clocks per UART bit (2..65535),
//                            DEPTH samples per trigger (1..256).
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_capture_tx
    import trig_capture_tx_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int DEPTH   = 16
) (
    input  wire              CLOCK_50,
    input  wire              RESET_N,
    trig_capture_tx_if.slave bus
);

    localparam int NBYTES = 2 * DEPTH + 1;
    // Byte index must be able to hold NBYTES itself ("everything issued").
    localparam int BIW    = $clog2(NBYTES + 1);
    localparam int SW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           r_state;
    logic             r_trig_d;
    logic             r_busy;
    logic             r_kick;      // first cycle of SEND: launch the header
    logic [SW-1:0]    r_cap_idx;
    logic [BIW-1:0]   r_byte_idx;  // index of the next byte to hand to the UART
    logic [ADC_W-1:0] r_buf [DEPTH];

    logic             w_edge;
    logic             w_buf_we;
    logic [SW-1:0]    w_buf_addr;
    logic             w_start;
    logic             w_done;
    logic             w_tx;
    logic [BIW-1:0]   w_k;
    logic [SW-1:0]    w_samp;
    logic [7:0]       w_byte;

    assign w_edge = bus.trigger & ~r_trig_d;

    // The edge cycle itself stores sample 0, so capture has no dead clock.
    assign w_buf_we   = ((r_state == ST_IDLE) && w_edge) || (r_state == ST_CAPTURE);
    assign w_buf_addr = (r_state == ST_CAPTURE) ? r_cap_idx : '0;

    always_ff @(posedge CLOCK_50) begin
        if (w_buf_we) begin
            r_buf[w_buf_addr] <= bus.ADC_IN;
        end
    end

    // Byte r_byte_idx: 0 is the header, then (k-1)/2 selects the sample and
    // the parity of k-1 picks high (even) or low (odd) half.
    always_comb begin
        w_k    = r_byte_idx - 1'b1;
        w_samp = '0;
        w_byte = HEADER;
        if (r_byte_idx != '0) begin
            w_samp = SW'(w_k >> 1);
            w_byte = sample_byte(r_buf[w_samp], ~w_k[0]);
        end
    end

    // Next byte is issued during the last stop-bit clock so frames abut.
    assign w_start = (r_state == ST_SEND) &&
                     (r_kick || (w_done && (r_byte_idx != BIW'(NBYTES))));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_trig_d   <= 1'b0;
            r_busy     <= 1'b0;
            r_kick     <= 1'b0;
            r_cap_idx  <= '0;
            r_byte_idx <= '0;
        end else begin
            r_trig_d <= bus.trigger;
            r_kick   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_busy     <= 1'b1;
                        r_byte_idx <= '0;
                        if (DEPTH == 1) begin
                            r_state <= ST_SEND;
                            r_kick  <= 1'b1;
                        end else begin
                            r_state   <= ST_CAPTURE;
                            r_cap_idx <= SW'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (r_cap_idx == SW'(DEPTH - 1)) begin
                        r_state   <= ST_SEND;
                        r_kick    <= 1'b1;
                        r_cap_idx <= '0;
                    end else begin
                        r_cap_idx <= r_cap_idx + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_start) begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                    end
                    if (w_done && (r_byte_idx == BIW'(NBYTES))) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_byte_idx <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_uart (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .i_data  (w_byte),
        .i_start (w_start),
        .o_tx    (w_tx),
        .o_done  (w_done)
    );

    assign bus.tx   = w_tx;
    assign bus.busy = r_busy;

endmodule
`default_nettype wire
